// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: next-PC select, fetch FSM states and PC constants.
package rv32i_pkg;

    typedef enum logic {
        PC_4   = 1'b0,
        PC_ALU = 1'b1
    } PCSel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch with a request/grant/response
// handshake; responses overtaken by a PC update are dropped.
module pc_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  PCSel_e      i_pc_sel,
    input  logic        i_pc_en,
    input  logic [31:0] i_alu_res,
    output logic [31:0] o_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic        o_misalign,
    output logic [31:0] o_misalign_addr
);

    fetch_state_e state;
    logic [31:0]  pc_next;
    logic [31:0]  req_pc;
    logic         kill;
    logic         misalign_evt;
    logic         pc_upd;

    // A jump target with bit 1 set traps instead of updating the PC.
    assign misalign_evt = i_pc_en && (i_pc_sel == PC_ALU) && i_alu_res[1];
    assign pc_upd       = i_pc_en && !misalign_evt;
    assign pc_next      = (i_pc_sel == PC_ALU) ? {i_alu_res[31:2], 2'b00} : o_pc + PC_INCR;

    assign o_imem_req  = (state == REQ);
    assign o_imem_addr = o_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pc            <= RESET_VECTOR;
            o_misalign      <= 1'b0;
            o_misalign_addr <= 32'h0;
        end else begin
            o_misalign <= misalign_evt;
            if (misalign_evt) o_misalign_addr <= i_alu_res;
            if (pc_upd)       o_pc            <= pc_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            req_pc        <= 32'h0;
            kill          <= 1'b0;
            o_instr       <= 32'h0;
            o_instr_pc    <= 32'h0;
            o_instr_valid <= 1'b0;
        end else begin
            o_instr_valid <= 1'b0;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (i_imem_gnt) begin
                        // Grant carries the pre-update PC; an update in this same cycle kills it.
                        req_pc <= o_pc;
                        kill   <= pc_upd;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (i_imem_rvalid) begin
                        if (!(kill || pc_upd)) begin
                            o_instr       <= i_imem_rdata;
                            o_instr_pc    <= req_pc;
                            o_instr_valid <= 1'b1;
                        end
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill <= kill || pc_upd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: PC-update vector table plus fetch/kill/reset sequences.
module tb_pc_fetch_unit;
    import rv32i_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    PCSel_e      i_pc_sel = PC_4;
    logic        i_pc_en = 1'b0;
    logic [31:0] i_alu_res = 32'h0;
    logic [31:0] o_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_valid;
    logic        o_misalign;
    logic [31:0] o_misalign_addr;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pc_sel       (i_pc_sel),
        .i_pc_en        (i_pc_en),
        .i_alu_res      (i_alu_res),
        .o_pc           (o_pc),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .o_instr_valid  (o_instr_valid),
        .o_misalign     (o_misalign),
        .o_misalign_addr(o_misalign_addr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        PCSel_e      sel;
        logic [31:0] alu;
        logic [31:0] exp_pc;
        logic        exp_mis;
        logic [31:0] exp_mis_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " pc"},        o_pc, 32'h100);
        chk({tag, " req"},       {31'b0, o_imem_req}, 32'h0);
        chk({tag, " instr"},     o_instr, 32'h0);
        chk({tag, " instr_pc"},  o_instr_pc, 32'h0);
        chk({tag, " valid"},     {31'b0, o_instr_valid}, 32'h0);
        chk({tag, " mis"},       {31'b0, o_misalign}, 32'h0);
        chk({tag, " mis_addr"},  o_misalign_addr, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, PC_4,   32'h0,         32'h104,       1'b0, 32'h0};
        vecs[1]  = '{1'b1, PC_4,   32'h0,         32'h108,       1'b0, 32'h0};
        vecs[2]  = '{1'b1, PC_4,   32'h0,         32'h10C,       1'b0, 32'h0};
        vecs[3]  = '{1'b1, PC_4,   32'h0,         32'h110,       1'b0, 32'h0};
        vecs[4]  = '{1'b1, PC_ALU, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, PC_4,   32'h0,         32'h0,         1'b0, 32'h0};
        vecs[6]  = '{1'b1, PC_ALU, 32'h2001,      32'h2000,      1'b0, 32'h0};
        vecs[7]  = '{1'b1, PC_ALU, 32'h2002,      32'h2000,      1'b1, 32'h2002};
        vecs[8]  = '{1'b0, PC_4,   32'h0,         32'h2000,      1'b0, 32'h2002};
        vecs[9]  = '{1'b0, PC_ALU, 32'h3,         32'h2000,      1'b0, 32'h2002};
        vecs[10] = '{1'b1, PC_4,   32'h0,         32'h2004,      1'b0, 32'h2002};
        vecs[11] = '{1'b1, PC_ALU, 32'h2003,      32'h2004,      1'b1, 32'h2003};

        // Reset state and first zero-wait fetch.
        #12;
        chk_reset_outs("rst");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("idle req", {31'b0, o_imem_req}, 32'h0);
        step();
        chk("first req", {31'b0, o_imem_req}, 32'h1);
        chk("first addr", o_imem_addr, 32'h100);
        i_imem_gnt = 1'b1;
        step();
        chk("resp req low", {31'b0, o_imem_req}, 32'h0);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hCAFE_0013;
        step();
        i_imem_rvalid = 1'b0;
        chk("first valid", {31'b0, o_instr_valid}, 32'h1);
        chk("first instr", o_instr, 32'hCAFE_0013);
        chk("first instr_pc", o_instr_pc, 32'h100);
        chk("first pc", o_pc, 32'h100);
        step();
        chk("valid pulse", {31'b0, o_instr_valid}, 32'h0);

        // PC update table, FSM parked in REQ with no grant.
        foreach (vecs[i]) begin
            i_pc_en = vecs[i].en; i_pc_sel = vecs[i].sel; i_alu_res = vecs[i].alu;
            step();
            chk($sformatf("v%0d pc", i), o_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d addr", i), o_imem_addr, vecs[i].exp_pc);
            chk($sformatf("v%0d mis", i), {31'b0, o_misalign}, {31'b0, vecs[i].exp_mis});
            chk($sformatf("v%0d mis_addr", i), o_misalign_addr, vecs[i].exp_mis_addr);
        end
        i_pc_en = 1'b0;

        // Kill: PC update during a 3-cycle response wait.
        i_pc_en = 1'b1; i_pc_sel = PC_ALU; i_alu_res = 32'h40;
        step();
        i_pc_en = 1'b0;
        chk("kill pc40", o_pc, 32'h40);
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        i_pc_en = 1'b1; i_pc_sel = PC_4;
        step();
        i_pc_en = 1'b0;
        step();
        step();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
        step();
        i_imem_rvalid = 1'b0;
        chk("kill no valid", {31'b0, o_instr_valid}, 32'h0);
        chk("kill instr kept", o_instr, 32'hCAFE_0013);
        chk("refetch req", {31'b0, o_imem_req}, 32'h1);
        chk("refetch addr", o_imem_addr, 32'h44);
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0093;
        step();
        i_imem_rvalid = 1'b0;
        chk("refetch valid", {31'b0, o_instr_valid}, 32'h1);
        chk("refetch instr", o_instr, 32'h0000_0093);
        chk("refetch instr_pc", o_instr_pc, 32'h44);

        // Grant coinciding with a PC update: killed, and refetch uses the new PC.
        i_imem_gnt = 1'b1; i_pc_en = 1'b1; i_pc_sel = PC_4;
        step();
        i_imem_gnt = 1'b0; i_pc_en = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1111_1111;
        step();
        i_imem_rvalid = 1'b0;
        chk("gnt+upd no valid", {31'b0, o_instr_valid}, 32'h0);
        chk("gnt+upd addr", o_imem_addr, 32'h48);

        // Response coinciding with a PC update: discarded.
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_2222; i_pc_en = 1'b1;
        step();
        i_imem_rvalid = 1'b0; i_pc_en = 1'b0;
        chk("rv+upd no valid", {31'b0, o_instr_valid}, 32'h0);
        chk("rv+upd pc", o_pc, 32'h4C);

        // Grant held low: request and address stay stable.
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("wait%0d req", c), {31'b0, o_imem_req}, 32'h1);
            chk($sformatf("wait%0d addr", c), o_imem_addr, 32'h4C);
        end

        // Reset while in RESP, then a late rvalid must be ignored.
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outs("mid rst");
        step();
        i_rst_n = 1'b1;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h3333_3333;
        step();
        i_imem_rvalid = 1'b0;
        chk("late rv valid", {31'b0, o_instr_valid}, 32'h0);
        chk("late rv instr", o_instr, 32'h0);
        chk("late rv req", {31'b0, o_imem_req}, 32'h1);
        step();
        chk("late rv valid2", {31'b0, o_instr_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch front end of the RV32I core. Holds the architectural PC, updates it from the core's PC-select controls (sequential PC+4 or ALU branch/jump target), and runs a request/grant/response handshake to instruction memory. Fetched words are delivered to decode tagged with their PC; a response whose fetch was overtaken by a PC update is discarded. A misaligned jump target raises an exception pulse.

## Interface

- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pc_sel  in  PCSel_e  next-PC source: PC_4 or PC_ALU.
- i_pc_en  in  1  commit a PC update this cycle.
- i_alu_res  in  32  branch/jump target from the ALU.
- o_pc  out  32  current architectural PC, registered.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  fetch address; equals o_pc combinationally.
- i_imem_gnt  in  1  memory accepts the request this cycle.
- i_imem_rvalid  in  1  read data valid.
- i_imem_rdata  in  32  fetched instruction word.
- o_instr  out  32  instruction delivered to decode.
- o_instr_pc  out  32  PC of o_instr.
- o_instr_valid  out  1  one-cycle pulse: o_instr/o_instr_pc are new.
- o_misalign  out  1  one-cycle pulse: instruction-address-misaligned exception.
- o_misalign_addr  out  32  offending target, held until the next misalign.

## Operation

- PC update, evaluated only when i_pc_en=1:
  - PC_4: pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - PC_ALU with i_alu_res[1]=0: pc <= {i_alu_res[31:2], 2'b00}. Bit 0 is cleared per JALR.
  - PC_ALU with i_alu_res[1]=1: pc holds. o_misalign pulses the next cycle and o_misalign_addr <= i_alu_res. This does not count as a PC update for the kill rule.
- o_pc[1:0] is 2'b00 at all times.
- Fetch FSM states: IDLE, REQ, RESP.
  - IDLE: entered on reset. Goes to REQ unconditionally on the next clock edge.
  - REQ: o_imem_req=1. On i_imem_gnt: req_pc <= o_pc, go to RESP. While waiting for grant, o_imem_addr tracks o_pc.
  - RESP: o_imem_req=0. On i_imem_rvalid:
    - if kill=0: o_instr <= i_imem_rdata, o_instr_pc <= req_pc, o_instr_valid pulses.
    - Always return to REQ and clear kill.
- Kill rule: kill is set by any PC update (i_pc_en with a non-misaligned result) in any cycle from the grant cycle through the rvalid cycle, inclusive. A response is delivered only if no such update occurred in that window.
- One outstanding fetch at most. i_imem_rvalid outside RESP is ignored. i_imem_gnt outside REQ is ignored.

## Timing

- Reset values: o_pc=RESET_VECTOR, FSM=IDLE, o_imem_req=0, o_instr=0, o_instr_pc=0, o_instr_valid=0, o_misalign=0, o_misalign_addr=0, kill=0.
- PC update latency: 1 cycle. o_pc reflects the update on the edge where i_pc_en is sampled.
- Fetch latency: o_instr_valid rises on the edge after the rvalid cycle. With zero-wait memory (gnt in the request cycle, rvalid the next cycle), one instruction is delivered every 2 cycles.
- First request is asserted in the second cycle after reset release.
- Simultaneous gnt and PC update: the grant carries the old PC and kill is set.
- Simultaneous rvalid and PC update: the response is discarded.
- Reset mid-fetch: all state returns to reset values. A late rvalid after reset is ignored, because the FSM is in IDLE or REQ.

## Structure

- PCSel_e (PC_4, PC_ALU) lives in rv32i_pkg.
- Add fetch_state_e (IDLE, REQ, RESP) to rv32i_pkg.
- Add a PC_INCR = 32'd4 constant to rv32i_pkg.
- Single module; a sub-module is not warranted. The PC register/next-PC logic and the fetch FSM are separate always blocks.

## Test plan

- Reset, RESET_VECTOR=32'h100, zero-wait memory, no i_pc_en → o_imem_req rises in cycle 2 with addr 32'h100. The response is delivered with o_instr_pc=32'h100. o_pc stays 32'h100.
- i_pc_en with PC_4 for 4 consecutive cycles from 32'h100 → o_pc steps 104, 108, 10C, 110. Then start from 32'hFFFF_FFFC with PC_4 → 32'h0.
- PC_ALU with i_alu_res=32'h2001 → o_pc=32'h2000. PC_ALU with 32'h2002 → o_pc holds, o_misalign pulses one cycle, o_misalign_addr=32'h2002.
- Grant at pc=32'h40, PC_4 update during a 3-cycle rvalid wait → no o_instr_valid. The next request is issued with addr 32'h44 and delivers o_instr_pc=32'h44.
- Hold i_imem_gnt low for 5 cycles → o_imem_req stays high and o_imem_addr stable. Assert reset while in RESP, then pulse rvalid → no o_instr_valid, and all outputs are at reset values.
